// File: rtl/ctrl_req_pkg.sv
// Shared types and constants for the class-specific control request engine.
// Also holds the SETUP field layout that the engine keeps after capture.
package ctrl_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SET_DATA,
    ST_GET_DATA,
    ST_DONE,
    ST_STALL
  } state_t;

  typedef enum logic [1:0] {
    KIND_SET,
    KIND_GET_CUR,
    KIND_GET_DEF,
    KIND_BAD
  } kind_t;

  localparam logic [7:0] REQ_OUT_CLASS_IF = 8'h21;
  localparam logic [7:0] REQ_IN_CLASS_IF  = 8'hA1;
  localparam logic [7:0] SET_CUR          = 8'h01;
  localparam logic [7:0] GET_CUR          = 8'h81;
  localparam logic [7:0] GET_DEF          = 8'h82;

  // Only the SETUP fields the engine acts on: wValue and wIndex[15:8] are ignored.
  typedef struct packed {
    logic [7:0]  req_type;
    logic [7:0]  request;
    logic [7:0]  index;
    logic [15:0] length;
  } setup_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_req_decode.sv
// Combinational classification of a captured SETUP packet into request kind,
// target channel, transfer length and legality.
module ctrl_req_decode
  import ctrl_req_pkg::*;
#(
  parameter int NUM_CTRL  = 4,
  parameter int REG_BYTES = 4,
  parameter int CH_W      = 2
) (
  input  setup_t          pkt,
  output kind_t           kind,
  output logic [CH_W-1:0] ch,
  output logic [3:0]      len,
  output logic            legal
);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    kind = KIND_BAD;
    if (pkt.req_type == REQ_OUT_CLASS_IF && pkt.request == SET_CUR)
      kind = KIND_SET;
    else if (pkt.req_type == REQ_IN_CLASS_IF && pkt.request == GET_CUR)
      kind = KIND_GET_CUR;
    else if (pkt.req_type == REQ_IN_CLASS_IF && pkt.request == GET_DEF)
      kind = KIND_GET_DEF;
  end

  assign ch = pkt.index[CH_W-1:0];

  // GET lengths clamp to the register size; an oversized SET is rejected instead.
  assign len = (pkt.length > 16'(REG_BYTES)) ? 4'(REG_BYTES) : pkt.length[3:0];

  assign legal = (kind != KIND_BAD) &&
                 (pkt.index < 8'(NUM_CTRL)) &&
                 !(kind == KIND_SET && pkt.length > 16'(REG_BYTES));

endmodule

// File: rtl/ctrl_req_engine.sv
// Endpoint-0 class control engine: SET_CUR / GET_CUR / GET_DEF on a bank of
// NUM_CTRL registers, with byte-stream payloads and atomic SET commit.
module ctrl_req_engine
  import ctrl_req_pkg::*;
#(
  parameter int                     NUM_CTRL  = 4,
  parameter int                     REG_BYTES = 4,
  parameter logic [8*REG_BYTES-1:0] DEFAULT   = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            setup_valid,
  input  logic [63:0]                     setup_data,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [7:0]                      out_data,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            stall,
  output logic [NUM_CTRL*8*REG_BYTES-1:0] ctrl_value,
  output logic [NUM_CTRL-1:0]             ctrl_update
);

  localparam int REG_W = 8 * REG_BYTES;
  localparam int CH_W  = ch_width(NUM_CTRL);

  state_t           state_q, state_d;
  setup_t           pkt_q;
  kind_t            kind;
  logic [CH_W-1:0]  ch;
  logic [3:0]       len;
  logic             legal;
  logic [3:0]       cnt;
  logic             last_byte;
  logic [REG_W-1:0] shadow, shadow_next, src_q;
  logic [REG_W-1:0] bank [NUM_CTRL];
  logic             unused_setup;

  assign unused_setup = ^setup_data[47:24];

  ctrl_req_decode #(
    .NUM_CTRL (NUM_CTRL),
    .REG_BYTES(REG_BYTES),
    .CH_W     (CH_W)
  ) u_decode (
    .pkt  (pkt_q),
    .kind (kind),
    .ch   (ch),
    .len  (len),
    .legal(legal)
  );

  assign last_byte = (cnt + 4'd1 == len);

  // A new SETUP wins over whatever the current state wanted to do next.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_DECODE: begin
        if (!legal)                state_d = ST_STALL;
        else if (len == 4'd0)      state_d = ST_DONE;
        else if (kind == KIND_SET) state_d = ST_SET_DATA;
        else                       state_d = ST_GET_DATA;
      end
      ST_SET_DATA: if (in_valid && last_byte)  state_d = ST_DONE;
      ST_GET_DATA: if (out_ready && last_byte) state_d = ST_DONE;
      ST_DONE, ST_STALL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (setup_valid) state_d = ST_DECODE;
  end

  always_comb begin
    shadow_next = shadow;
    for (int b = 0; b < REG_BYTES; b++)
      if (cnt == 4'(b)) shadow_next[b*8 +: 8] = in_data;
  end

  always_comb begin
    out_data = '0;
    if (state_q == ST_GET_DATA)
      for (int b = 0; b < REG_BYTES; b++)
        if (cnt == 4'(b)) out_data = src_q[b*8 +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the register bank is architectural state and must come out of reset at DEFAULT, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pkt_q       <= '0;
      cnt         <= '0;
      shadow      <= '0;
      src_q       <= '0;
      ctrl_update <= '0;
      for (int i = 0; i < NUM_CTRL; i++) bank[i] <= DEFAULT;
    end else begin
      state_q     <= state_d;
      ctrl_update <= '0;
      if (setup_valid) begin
        pkt_q <= {setup_data[63:48], setup_data[23:0]};
        cnt   <= '0;
      end else begin
        case (state_q)
          ST_DECODE: begin
            cnt    <= '0;
            shadow <= bank[ch];
            src_q  <= (kind == KIND_GET_DEF) ? DEFAULT : bank[ch];
          end
          ST_SET_DATA: begin
            if (in_valid) begin
              shadow <= shadow_next;
              cnt    <= cnt + 4'd1;
              if (last_byte) begin
                bank[ch]        <= shadow_next;
                ctrl_update[ch] <= 1'b1;
              end
            end
          end
          ST_GET_DATA: if (out_ready) cnt <= cnt + 4'd1;
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_flat
    assign ctrl_value[g*REG_W +: REG_W] = bank[g];
  end

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_SET_DATA);
  assign out_valid = (state_q == ST_GET_DATA);
  assign done      = (state_q == ST_DONE);
  assign stall     = (state_q == ST_STALL);

endmodule

// File: tb/tb_ctrl_req_engine.sv
// Scenario bench for ctrl_req_engine: directed cases plus random requests
// checked against a byte-level model of the register bank.
module tb_ctrl_req_engine;

  localparam int NUM_CTRL  = 4;
  localparam int REG_BYTES = 4;
  localparam int REG_W     = 32;
  localparam int FLAT_W    = NUM_CTRL * REG_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              setup_valid;
  logic [63:0]       setup_data;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic              busy, done, stall;
  logic [FLAT_W-1:0] ctrl_value;
  logic [NUM_CTRL-1:0] ctrl_update;

  always #5 clk = ~clk;

  ctrl_req_engine #(
    .NUM_CTRL (NUM_CTRL),
    .REG_BYTES(REG_BYTES),
    .DEFAULT  (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .setup_valid(setup_valid),
    .setup_data (setup_data),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .ctrl_value (ctrl_value),
    .ctrl_update(ctrl_update)
  );

  int total = 0;
  int bad   = 0;

  logic [REG_W-1:0] model_reg [NUM_CTRL];
  logic [7:0]       set_bytes [8];

  // Observations of the most recent transaction.
  logic [7:0]          obs_bytes [$];
  logic                obs_done, obs_stall, obs_busy_ok, obs_hold_ok;
  logic                obs_in_ready_seen, obs_out_valid_seen, obs_stray_update;
  logic [NUM_CTRL-1:0] obs_update;
  logic [FLAT_W-1:0]   obs_value;
  int                  obs_cycles;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLAT_W-1:0] model_flat();
    logic [FLAT_W-1:0] f;
    for (int i = 0; i < NUM_CTRL; i++) f[i*REG_W +: REG_W] = model_reg[i];
    return f;
  endfunction

  // 0 = stall, 1 = SET_CUR, 2 = GET_CUR, 3 = GET_DEF
  function automatic int classify(input logic [7:0] bm, input logic [7:0] br,
                                  input logic [15:0] wi, input logic [15:0] wl);
    if (int'(wi[7:0]) >= NUM_CTRL) return 0;
    if (bm == 8'h21 && br == 8'h01) return (int'(wl) <= REG_BYTES) ? 1 : 0;
    if (bm == 8'hA1 && br == 8'h81) return 2;
    if (bm == 8'hA1 && br == 8'h82) return 3;
    return 0;
  endfunction

  function automatic logic [REG_W-1:0] merge_set(input logic [REG_W-1:0] old, input int n);
    logic [REG_W-1:0] v = old;
    for (int i = 0; i < n; i++)
      v = (v & ~(32'hFF << (8 * i))) | (32'(set_bytes[i]) << (8 * i));
    return v;
  endfunction

  // Issues one SETUP and services the payload until done/stall.
  // mode 0: always ready/valid, 1: random handshakes, 2: out_ready toggles 1,0,1,...
  task automatic run_txn(input logic [7:0] bm, input logic [7:0] br,
                         input logic [15:0] wi, input logic [15:0] wl, input int mode);
    int  sent = 0;
    int  pat  = 0;
    logic prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic finished = 1'b0;
    obs_bytes.delete();
    obs_done = 0; obs_stall = 0; obs_busy_ok = 1; obs_hold_ok = 1;
    obs_in_ready_seen = 0; obs_out_valid_seen = 0; obs_stray_update = 0;
    obs_update = '0; obs_value = '0; obs_cycles = 0;
    in_valid    = 1'b0;
    setup_valid = 1'b1;
    setup_data  = {bm, br, 16'h5A5A, wi, wl};
    step;
    setup_valid = 1'b0;
    for (int cyc = 1; cyc < 200 && !finished; cyc++) begin
      if (!busy) obs_busy_ok = 0;
      if (done || stall) begin
        obs_done = done; obs_stall = stall; obs_update = ctrl_update;
        obs_value = ctrl_value; obs_cycles = cyc; finished = 1'b1;
      end else begin
        if (ctrl_update != '0) obs_stray_update = 1;
        if (in_ready) obs_in_ready_seen = 1;
        if (out_valid) begin
          obs_out_valid_seen = 1;
          if (prev_hold && out_data !== prev_data) obs_hold_ok = 0;
        end
        in_valid = (sent < 8) && (mode != 1 || $urandom_range(0, 1) == 1);
        in_data  = set_bytes[sent < 8 ? sent : 7];
        if (mode == 1)      out_ready = ($urandom_range(0, 1) == 1);
        else if (mode == 2) out_ready = out_valid ? (pat % 2 == 0) : 1'b1;
        else                out_ready = 1'b1;
        if (mode == 2 && out_valid) pat++;
        if (in_ready && in_valid) sent++;
        if (out_valid && out_ready) obs_bytes.push_back(out_data);
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        step;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!finished) $display("FAIL txn_timeout: no done/stall within 200 cycles for %h/%h", bm, br);
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    total++; if ({busy, in_ready, out_valid, done, stall} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {busy, in_ready, out_valid, done, stall}); end
    total++; if (ctrl_update !== '0 || out_data !== 8'h00) begin bad++; $display("FAIL reset_outs: update=%b data=%h want 0/00", ctrl_update, out_data); end
    total++; if (ctrl_value !== model_flat()) begin bad++; $display("FAIL reset_value: got %h want %h", ctrl_value, model_flat()); end
    rst = 1'b0;
    step;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_get_default;
    run_txn(8'hA1, 8'h81, 16'h0001, 16'h0004, 0);
    total++; if (obs_bytes.size() != 4) begin bad++; $display("FAIL get_def_count: got %0d want 4", obs_bytes.size()); end
    foreach (obs_bytes[i]) begin
      total++; if (obs_bytes[i] !== 8'h00) begin bad++; $display("FAIL get_def_byte%0d: got %h want 00", i, obs_bytes[i]); end
    end
    total++; if (obs_done !== 1'b1 || obs_cycles != 6) begin bad++; $display("FAIL get_def_done: done=%b cyc=%0d want 1/6", obs_done, obs_cycles); end
    total++; if (obs_busy_ok !== 1'b1) begin bad++; $display("FAIL get_def_busy: busy dropped mid-request, want high"); end
  endtask

  task automatic test_set_basic;
    logic [7:0] want [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) set_bytes[i] = want[i];
    run_txn(8'h21, 8'h01, 16'h0002, 16'h0004, 0);
    model_reg[2] = 32'h44332211;
    total++; if (obs_done !== 1'b1 || obs_cycles != 6) begin bad++; $display("FAIL set_done: done=%b cyc=%0d want 1/6", obs_done, obs_cycles); end
    total++; if (obs_update !== 4'b0100) begin bad++; $display("FAIL set_update: got %b want 0100", obs_update); end
    total++; if (obs_value[2*REG_W +: REG_W] !== 32'h44332211) begin bad++; $display("FAIL set_value: got %h want 44332211", obs_value[2*REG_W +: REG_W]); end
    total++; if (obs_value !== model_flat()) begin bad++; $display("FAIL set_bank: got %h want %h", obs_value, model_flat()); end
    run_txn(8'hA1, 8'h81, 16'h0002, 16'h0004, 0);
    total++; if (obs_bytes.size() != 4) begin bad++; $display("FAIL set_readback_count: got %0d want 4", obs_bytes.size()); end
    foreach (obs_bytes[i]) begin
      total++; if (i < 4 && obs_bytes[i] !== want[i]) begin bad++; $display("FAIL set_readback%0d: got %h want %h", i, obs_bytes[i], want[i]); end
    end
  endtask

  task automatic test_get_backpressure;
    run_txn(8'hA1, 8'h81, 16'h0002, 16'h0002, 2);
    total++; if (obs_bytes.size() != 2 || obs_bytes[0] !== 8'h11 || obs_bytes[1] !== 8'h22) begin bad++; $display("FAIL bp_bytes: got %p want 11,22", obs_bytes); end
    total++; if (obs_hold_ok !== 1'b1) begin bad++; $display("FAIL bp_hold: out_data changed while out_ready low"); end
    total++; if (obs_done !== 1'b1 || obs_cycles != 5) begin bad++; $display("FAIL bp_done: done=%b cyc=%0d want 1/5", obs_done, obs_cycles); end
    run_txn(8'hA1, 8'h81, 16'h0002, 16'h0009, 0);
    total++; if (obs_bytes.size() != 4 || obs_cycles != 6) begin bad++; $display("FAIL bp_clamp: got %0d bytes cyc=%0d want 4/6", obs_bytes.size(), obs_cycles); end
  endtask

  task automatic test_illegal;
    logic [7:0]  bms [3] = '{8'h21, 8'hA1, 8'h21};
    logic [7:0]  brs [3] = '{8'h01, 8'h85, 8'h01};
    logic [15:0] wis [3] = '{16'h0004, 16'h0000, 16'h0000};
    logic [15:0] wls [3] = '{16'h0004, 16'h0004, 16'h0005};
    for (int k = 0; k < 3; k++) begin
      run_txn(bms[k], brs[k], wis[k], wls[k], 0);
      total++; if (obs_stall !== 1'b1 || obs_done !== 1'b0 || obs_cycles != 2) begin bad++; $display("FAIL illegal%0d_stall: stall=%b done=%b cyc=%0d want 1/0/2", k, obs_stall, obs_done, obs_cycles); end
      total++; if (obs_in_ready_seen || obs_out_valid_seen) begin bad++; $display("FAIL illegal%0d_hs: in_ready=%b out_valid=%b want 0/0", k, obs_in_ready_seen, obs_out_valid_seen); end
      total++; if (obs_value !== model_flat()) begin bad++; $display("FAIL illegal%0d_value: got %h want %h", k, obs_value, model_flat()); end
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 4; i++) set_bytes[i] = 8'($urandom_range(1, 255));
    run_txn(8'h21, 8'h01, 16'h0000, 16'h0004, 0);
    model_reg[0] = merge_set(model_reg[0], 4);
    total++; if (obs_value !== model_flat()) begin bad++; $display("FAIL abort_precommit: got %h want %h", obs_value, model_flat()); end
    setup_valid = 1'b1; setup_data = {8'h21, 8'h01, 16'h0000, 16'h0000, 16'h0004};
    step;
    setup_valid = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    step;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    step;
    in_data = 8'hBB;
    step;
    in_valid = 1'b0;
    run_txn(8'hA1, 8'h82, 16'h0000, 16'h0004, 0);
    total++; if (obs_update !== '0 || obs_stray_update) begin bad++; $display("FAIL abort_update: got %b stray=%b want 0", obs_update, obs_stray_update); end
    total++; if (obs_value !== model_flat()) begin bad++; $display("FAIL abort_value: got %h want %h", obs_value, model_flat()); end
    total++; if (obs_bytes.size() != 4 || obs_done !== 1'b1) begin bad++; $display("FAIL abort_getdef: got %0d bytes done=%b want 4/1", obs_bytes.size(), obs_done); end
    foreach (obs_bytes[i]) begin
      total++; if (obs_bytes[i] !== 8'h00) begin bad++; $display("FAIL abort_def%0d: got %h want 00", i, obs_bytes[i]); end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  bm, br;
      logic [15:0] wi, wl;
      logic [REG_W-1:0] src;
      int kind, mode, ch, len, want_cyc;
      bm = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 1) ? 8'h21 : 8'hA1);
      case ($urandom_range(0, 4))
        0: br = 8'h01;
        1: br = 8'h81;
        2: br = 8'h82;
        3: br = 8'($urandom);
        default: br = (bm == 8'h21) ? 8'h01 : 8'h81;
      endcase
      wi = {8'($urandom), 8'($urandom_range(0, 5))};
      wl = ($urandom_range(0, 7) == 0) ? 16'h0100 + 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 9));
      mode = $urandom_range(0, 1);
      for (int i = 0; i < 8; i++) set_bytes[i] = 8'($urandom);
      kind = classify(bm, br, wi, wl);
      ch   = int'(wi[7:0]);
      len  = (int'(wl) > REG_BYTES) ? REG_BYTES : int'(wl);
      run_txn(bm, br, wi, wl, mode);
      total++; if (!obs_busy_ok || !obs_hold_ok || obs_stray_update) begin bad++; $display("FAIL rand%0d_proto: busy=%b hold=%b stray=%b want 1/1/0", t, obs_busy_ok, obs_hold_ok, obs_stray_update); end
      want_cyc = 2;
      if (kind == 0) begin
        total++; if (obs_stall !== 1'b1 || obs_in_ready_seen || obs_out_valid_seen) begin bad++; $display("FAIL rand%0d_stall: stall=%b ir=%b ov=%b want 1/0/0", t, obs_stall, obs_in_ready_seen, obs_out_valid_seen); end
      end else if (kind == 1) begin
        model_reg[ch] = merge_set(model_reg[ch], len);
        want_cyc = 2 + len;
        total++; if (obs_done !== 1'b1 || obs_update !== ((len == 0) ? 4'b0 : 4'(1 << ch))) begin bad++; $display("FAIL rand%0d_set: done=%b update=%b ch=%0d len=%0d", t, obs_done, obs_update, ch, len); end
      end else begin
        src = (kind == 3) ? 32'h0 : model_reg[ch];
        want_cyc = 2 + len;
        total++; if (obs_done !== 1'b1 || obs_bytes.size() != len) begin bad++; $display("FAIL rand%0d_get: done=%b bytes=%0d want 1/%0d", t, obs_done, obs_bytes.size(), len); end
        foreach (obs_bytes[i]) begin
          total++; if (obs_bytes[i] !== 8'((src >> (8 * i)) & 32'hFF)) begin bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", t, i, obs_bytes[i], 8'((src >> (8 * i)) & 32'hFF)); end
        end
      end
      if (mode == 0) begin
        total++; if (obs_cycles != want_cyc) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", t, obs_cycles, want_cyc); end
      end
      total++; if (obs_value !== model_flat()) begin bad++; $display("FAIL rand%0d_bank: got %h want %h", t, obs_value, model_flat()); end
    end
  endtask

  task automatic test_reset_mid;
    set_bytes[0] = 8'hC3; set_bytes[1] = 8'h5E; set_bytes[2] = 8'h99; set_bytes[3] = 8'h17;
    run_txn(8'h21, 8'h01, 16'h0003, 16'h0004, 0);
    total++; if (obs_value[3*REG_W +: REG_W] !== 32'h17995EC3) begin bad++; $display("FAIL rmid_commit: got %h want 17995ec3", obs_value[3*REG_W +: REG_W]); end
    setup_valid = 1'b1; setup_data = {8'h21, 8'h01, 16'h0000, 16'h0001, 16'h0004};
    step;
    setup_valid = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    step; step;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NUM_CTRL; i++) model_reg[i] = 32'h0;
    total++; if (ctrl_value !== model_flat()) begin bad++; $display("FAIL rmid_value: got %h want %h", ctrl_value, model_flat()); end
    total++; if ({busy, in_ready, out_valid} !== 3'b000) begin bad++; $display("FAIL rmid_flags: got %b want 000", {busy, in_ready, out_valid}); end
    #2 rst = 1'b0;
    in_valid = 1'b0;
    step;
    run_txn(8'hA1, 8'h81, 16'h0003, 16'h0004, 0);
    total++; if (obs_bytes.size() != 4 || obs_bytes[0] !== 8'h00 || obs_bytes[3] !== 8'h00) begin bad++; $display("FAIL rmid_readback: got %p want 00 x4", obs_bytes); end
  endtask

  initial begin
    setup_valid = 1'b0; setup_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < NUM_CTRL; i++) model_reg[i] = 32'h0;
    for (int i = 0; i < 8; i++) set_bytes[i] = 8'h00;
    test_reset;
    test_get_default;
    test_set_basic;
    test_get_backpressure;
    test_illegal;
    test_abort;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_req_engine.md
Name: ctrl_req_engine

Overview:
Parametrised successor to the single-register class control handler in the USB endpoint-0 path. It captures an 8-byte SETUP packet and decodes class-specific SET_CUR, GET_CUR and GET_DEF requests addressed to one of NUM_CTRL control registers, selected by wIndex. SET payload arrives as a byte stream and GET payload leaves as a byte stream, both with valid/ready handshakes. Unsupported or out-of-range requests produce a stall; a SET commits its data atomically only after the last byte arrives.

Parameters:
NUM_CTRL, 4, number of control registers (1..16)
REG_BYTES, 4, bytes per control register (1..8); REG_W = 8*REG_BYTES
DEFAULT, {REG_W{1'b0}}, reset value of every register and the value returned by GET_DEF

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, asynchronous and active-high
setup_valid  in  1  one-cycle strobe: setup_data holds a new SETUP packet
setup_data  in  64  [63:56] bmRequestType, [55:48] bRequest, [47:32] wValue, [31:16] wIndex, [15:0] wLength
in_valid  in  1  SET payload byte valid
in_data  in  8  SET payload byte
in_ready  out  1  engine accepts in_data
out_valid  out  1  GET payload byte valid
out_data  out  8  GET payload byte
out_ready  in  1  host side accepts out_data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: request completed successfully
stall  out  1  one-cycle pulse: request rejected
ctrl_value  out  NUM_CTRL*REG_W  flat register bank; channel i occupies [i*REG_W +: REG_W]
ctrl_update  out  NUM_CTRL  one-hot, one-cycle pulse on the channel committed by a SET_CUR

Behaviour:
- Reset: state IDLE; ctrl_value all DEFAULT; in_ready, out_valid, done, stall, ctrl_update and busy = 0; out_data = 0; byte counter = 0.
- States: IDLE, DECODE, SET_DATA, GET_DATA, DONE, STALL.
- IDLE: setup_valid high -> register the packet and go to DECODE.
- DECODE takes one cycle. ch = wIndex[7:0]. Decisions:
  - 0x21/0x01 SET_CUR with ch<NUM_CTRL and wLength<=REG_BYTES: wLength=0 -> DONE with no commit; otherwise SET_DATA.
  - 0xA1/0x81 GET_CUR or 0xA1/0x82 GET_DEF with ch<NUM_CTRL: len = min(wLength, REG_BYTES). len=0 -> DONE; otherwise GET_DATA.
  - Any other combination, ch>=NUM_CTRL, or SET with wLength>REG_BYTES -> STALL.
- SET_DATA: in_ready=1. Each in_valid&&in_ready cycle writes the byte into shadow byte[cnt], LSB first, and increments cnt. Shadow bytes at or above wLength keep the current register value. After the wLength-th byte the next state is DONE. ctrl_value[ch] is written from the shadow on the DONE cycle, and ctrl_update[ch] pulses on that same cycle.
- GET_DATA: out_valid=1 and out_data = byte[cnt] of the source (ctrl_value[ch] for GET_CUR, DEFAULT for GET_DEF), LSB first. The source is sampled once at entry; later commits do not alter an in-flight response. On out_valid&&out_ready, cnt increments; after len bytes the next state is DONE. out_data is held stable while out_ready is low.
- DONE: done=1 for one cycle, then IDLE. STALL: stall=1 for one cycle, then IDLE.
- setup_valid in any non-IDLE state aborts the current request. The new packet is captured and the next state is DECODE. No commit, no done and no stall are issued for the aborted request, and the shadow is discarded. This also applies in the DONE/STALL cycle: that pulse still fires and the next state is DECODE.
- Latency: setup_valid at edge N -> DECODE at N+1 -> first in_ready/out_valid at N+2. A SET with zero-wait data of L bytes gives done at N+2+L.
- Async rst mid-transfer: everything returns to reset values immediately, including ctrl_value.
- cnt is 4 bits wide and never wraps, because len <= 8.

Decomposition:
- Package ctrl_req_pkg holds the state enum, the request-type constants (REQ_OUT_CLASS_IF=8'h21, REQ_IN_CLASS_IF=8'hA1) and the bRequest codes (SET_CUR=8'h01, GET_CUR=8'h81, GET_DEF=8'h82).
- One sub-module, ctrl_req_decode, does the combinational classification of the registered packet into {kind, ch, len, legal}. The FSM, shadow and register bank stay in the top.

Test Plan:
- Reset, then GET_CUR ch1 with wLength=4 and out_ready=1 -> out_data 00,00,00,00 over 4 cycles, then done; busy is high throughout.
- SET_CUR {21,01,0000,0002,0004} with bytes 11,22,33,44 -> ctrl_value[2]=32'h44332211 and ctrl_update=4'b0100 in the done cycle; a following GET_CUR ch2 returns 11,22,33,44.
- GET_CUR ch2 with wLength=2 and out_ready toggling 1,0,1 -> exactly 11,22 with out_data held during the ready-low cycle; wLength=9 -> 4 bytes only.
- Illegal requests: wIndex=4, bRequest=0x85, or SET with wLength=5 -> stall pulse two cycles after setup_valid; no in_ready, no out_valid, ctrl_value unchanged.
- SET_CUR ch0 receives 2 of 4 bytes, then a new setup_valid (GET_DEF ch0) -> no ctrl_update, ctrl_value[0] unchanged, DEFAULT bytes streamed, then done.
- Assert rst during SET_DATA after a prior commit -> all ctrl_value return to DEFAULT, and busy, in_ready and out_valid are 0 in the same cycle.
